output_packer: RTL and testbench

OUTPUT_PACKER -- requirements
Module: output_packer

---
 rtl/output_packer_if.sv | 33 +++
 rtl/output_packer.sv | 136 +++++++++++++
 tb/tb_output_packer.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/output_packer_if.sv
// Job, psum-stream and output-SRAM signal bundle for output_packer.
// slave = the packer itself; master = the EPU controller / stream source side.
interface output_packer_if #(
    parameter int unsigned ADDR_W = 18,
    parameter int unsigned LEN_W  = 20
) ();
    logic              start_i;
    logic [ADDR_W-1:0] base_i;
    logic [LEN_W-1:0]  len_i;
    logic [4:0]        shift_i;
    logic              in_valid_i;
    logic              in_ready_o;
    logic [31:0]       in_psum_i;
    logic              sram_cs_o;
    logic              sram_oe_o;
    logic [ADDR_W-1:0] sram_addr_o;
    logic [3:0]        sram_wen_o;
    logic [31:0]       sram_wdata_o;
    logic              busy_o;
    logic              finish_o;

    modport slave (
        input  start_i, base_i, len_i, shift_i, in_valid_i, in_psum_i,
        output in_ready_o, sram_cs_o, sram_oe_o, sram_addr_o, sram_wen_o,
               sram_wdata_o, busy_o, finish_o
    );

    modport master (
        output start_i, base_i, len_i, shift_i, in_valid_i, in_psum_i,
        input  in_ready_o, sram_cs_o, sram_oe_o, sram_addr_o, sram_wen_o,
               sram_wdata_o, busy_o, finish_o
    );
endinterface

// File: rtl/output_packer.sv
// Requantizes a 32-bit psum stream to int8 and packs 4 bytes per output-SRAM word write.
// Optional macro OUTPUT_PACKER_RELU_EN clamps negative quantized values to 0.
module output_packer #(
    parameter int unsigned ADDR_W = 18,
    parameter int unsigned LEN_W  = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    output_packer_if.slave   bus
);

    typedef enum logic [1:0] {IDLE, RUN, LAST, DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic [4:0]        shift_q, shift_d;
    logic [31:0]       pack_q, pack_d;
    logic              wr_cs_q, wr_cs_d;
    logic [3:0]        wr_wen_q, wr_wen_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [31:0]       wr_data_q, wr_data_d;
    logic              in_ready_q, busy_q, finish_q;

    logic signed [32:0] q_rnd, q_sum, q_shr;
    logic [7:0]         q_byte;
    logic [1:0]         lane;
    logic               acc, last_byte;

    // Round-half-up, arithmetic shift, saturate to int8 (or [0,127] with ReLU).
    always_comb begin
        q_rnd  = '0;
        if (shift_q != 5'd0) q_rnd = 33'sd1 <<< (shift_q - 5'd1);
        q_sum  = $signed({bus.in_psum_i[31], bus.in_psum_i}) + q_rnd;
        q_shr  = q_sum >>> shift_q;
        q_byte = q_shr[7:0];
`ifdef OUTPUT_PACKER_RELU_EN
        if (q_shr < 33'sd0)          q_byte = 8'h00;
        else if (q_shr > 33'sd127)   q_byte = 8'h7F;
`else
        if (q_shr > 33'sd127)        q_byte = 8'h7F;
        else if (q_shr < -33'sd128)  q_byte = 8'h80;
`endif
    end

    assign lane      = cnt_q[1:0];
    assign acc       = bus.in_valid_i && (state_q == RUN);
    assign last_byte = (cnt_q == len_q - LEN_W'(1));

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        pack_d    = pack_q;
        wr_cs_d   = 1'b0;
        wr_wen_d  = 4'h0;
        wr_addr_d = '0;
        wr_data_d = 32'h0;
        case (state_q)
            IDLE: begin
                if (bus.start_i) begin
                    ptr_d   = bus.base_i;
                    len_d   = bus.len_i;
                    shift_d = bus.shift_i;
                    cnt_d   = '0;
                    pack_d  = 32'h0;
                    state_d = (bus.len_i == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (acc) begin
                    pack_d[{lane, 3'b000} +: 8] = q_byte;
                    cnt_d = cnt_q + LEN_W'(1);
                    // Flush on a full word or on the job's final byte.
                    if (lane == 2'd3 || last_byte) begin
                        wr_cs_d   = 1'b1;
                        wr_wen_d  = 4'((5'd2 << lane) - 5'd1);
                        wr_addr_d = ptr_q;
                        wr_data_d = pack_d;
                        ptr_d     = ptr_q + ADDR_W'(1);
                        pack_d    = 32'h0;
                    end
                    if (last_byte) state_d = LAST;
                end
            end
            LAST: state_d = DONE;
            DONE: if (!bus.start_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            len_q      <= '0;
            cnt_q      <= '0;
            shift_q    <= 5'd0;
            pack_q     <= 32'h0;
            wr_cs_q    <= 1'b0;
            wr_wen_q   <= 4'h0;
            wr_addr_q  <= '0;
            wr_data_q  <= 32'h0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            finish_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            pack_q     <= pack_d;
            wr_cs_q    <= wr_cs_d;
            wr_wen_q   <= wr_wen_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            in_ready_q <= (state_d == RUN);
            busy_q     <= (state_d != IDLE);
            finish_q   <= (state_d == DONE);
        end
    end

    assign bus.in_ready_o   = in_ready_q;
    assign bus.busy_o       = busy_q;
    assign bus.finish_o     = finish_q;
    assign bus.sram_cs_o    = wr_cs_q;
    assign bus.sram_oe_o    = 1'b0;
    assign bus.sram_wen_o   = wr_wen_q;
    assign bus.sram_addr_o  = wr_addr_q;
    assign bus.sram_wdata_o = wr_data_q;

endmodule

// File: tb/tb_output_packer.sv
// Directed self-checking bench for output_packer; honours OUTPUT_PACKER_RELU_EN.
module tb_output_packer;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    output_packer_if #(.ADDR_W(18), .LEN_W(20)) bus ();

    output_packer #(.ADDR_W(18), .LEN_W(20)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int          n_chk = 0;
    int          n_bad = 0;
    int          cyc   = 0;
    int          idle_viol = 0;
    int          fin_cyc;
    logic [31:0] pv [0:7];
    logic [31:0] wa[$], ww[$], wd[$];
    int          wc[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Capture every write; any non-zero SRAM output outside a write is a violation.
    always @(negedge clk) begin
        if (bus.sram_cs_o) begin
            wa.push_back(32'(bus.sram_addr_o));
            ww.push_back(32'(bus.sram_wen_o));
            wd.push_back(bus.sram_wdata_o);
            wc.push_back(cyc);
        end else if (bus.sram_wen_o != 4'h0 || bus.sram_addr_o != '0 || bus.sram_wdata_o != 32'h0) begin
            idle_viol++;
        end
        if (bus.sram_oe_o) idle_viol++;
    end

    task automatic clear_wr();
        wa.delete(); ww.delete(); wd.delete(); wc.delete();
    endtask

    task automatic check_wr(input int k, input logic [31:0] a, input logic [31:0] w, input logic [31:0] d);
        if (wa.size() > k) begin
            check($sformatf("wr%0d_addr", k), wa[k], a);
            check($sformatf("wr%0d_wen", k), ww[k], w);
            check($sformatf("wr%0d_data", k), wd[k], d);
        end else begin
            check($sformatf("wr%0d_missing", k), 32'(wa.size()), 32'(k + 1));
        end
    endtask

    task automatic run_job(input logic [17:0] b, input logic [19:0] l, input logic [4:0] sh,
                           input int nfeed, input bit drop_start);
        int i, g;
        @(negedge clk);
        bus.start_i = 1'b1; bus.base_i = b; bus.len_i = l; bus.shift_i = sh;
        bus.in_valid_i = 1'b0;
        i = 0; g = 0;
        while (i < nfeed && g < 64) begin
            @(negedge clk);
            bus.in_valid_i = 1'b1;
            bus.in_psum_i  = pv[i];
            if (bus.in_ready_o) begin
                i++;
                if (drop_start) bus.start_i = 1'b0;
            end
            g++;
        end
        if (i < nfeed) check("feed_timeout", 32'(i), 32'(nfeed));
        if (nfeed < int'(l)) return;
        @(negedge clk);
        bus.in_valid_i = 1'b0;
        check("ready_after_final", 32'(bus.in_ready_o), 32'd0);
        g = 1;
        while (!bus.finish_o && g < 20) begin
            @(negedge clk);
            g++;
        end
        fin_cyc = cyc;
        check("finish_seen", 32'(bus.finish_o), 32'd1);
        check("busy_in_done", 32'(bus.busy_o), 32'd1);
        if (l == '0) check("len0_finish_wait", 32'(g), 32'd1);
        else if (wc.size() > 0) check("finish_latency", 32'(fin_cyc - wc[wc.size()-1]), 32'd1);
        bus.start_i = 1'b0;
        @(negedge clk);
        check("finish_cleared", 32'(bus.finish_o), 32'd0);
        check("busy_cleared", 32'(bus.busy_o), 32'd0);
    endtask

    initial begin
        logic [31:0] e32, e34;
        bus.start_i = 1'b0; bus.base_i = '0; bus.len_i = '0; bus.shift_i = '0;
        bus.in_valid_i = 1'b0; bus.in_psum_i = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(bus.busy_o), 32'd0);
        check("rst_ready", 32'(bus.in_ready_o), 32'd0);
        check("rst_finish", 32'(bus.finish_o), 32'd0);
        check("rst_cs", 32'(bus.sram_cs_o), 32'd0);
        rst_n = 1'b1;

        // Basic two full words, back-to-back stream.
        clear_wr();
        for (int k = 0; k < 8; k++) pv[k] = 32'(k + 1);
        run_job(18'h100, 20'd8, 5'd0, 8, 1'b0);
        check("j1_nwr", 32'(wa.size()), 32'd2);
        check_wr(0, 32'h100, 32'hF, 32'h04030201);
        check_wr(1, 32'h101, 32'hF, 32'h08070605);
        if (wc.size() == 2) check("j1_no_bubble", 32'(wc[1] - wc[0]), 32'd4);

        // Partial last word; start dropped mid-job must be ignored.
        clear_wr();
        for (int k = 0; k < 5; k++) pv[k] = 32'h10 + 32'(k);
        run_job(18'h200, 20'd5, 5'd0, 5, 1'b1);
        check("j2_nwr", 32'(wa.size()), 32'd2);
        check_wr(0, 32'h200, 32'hF, 32'h13121110);
        check_wr(1, 32'h201, 32'h1, 32'h00000014);

        // Rounding/saturation corners.
        clear_wr();
        pv[0] = 32'h7FFFFFFF; pv[1] = 32'h80000000; pv[2] = 32'd24; pv[3] = -32'sd24;
`ifdef OUTPUT_PACKER_RELU_EN
        e32 = 32'h0002007F;
        e34 = 32'h007F0000;
`else
        e32 = 32'hFF02807F;
        e34 = 32'h807FFEFF;
`endif
        run_job(18'h30, 20'd4, 5'd4, 4, 1'b0);
        check("j3_nwr", 32'(wa.size()), 32'd1);
        check_wr(0, 32'h30, 32'hF, e32);

        // Empty job.
        clear_wr();
        run_job(18'h77, 20'd0, 5'd0, 0, 1'b0);
        check("j4_nwr", 32'(wa.size()), 32'd0);

        // Address wrap past the top, shift=1 rounding.
        clear_wr();
        pv[0] = 32'd2;  pv[1] = 32'd4;  pv[2] = 32'd6;    pv[3] = 32'd8;
        pv[4] = -32'sd2; pv[5] = -32'sd4; pv[6] = 32'd300; pv[7] = -32'sd300;
        run_job(18'h3FFFF, 20'd8, 5'd1, 8, 1'b0);
        check("j5_nwr", 32'(wa.size()), 32'd2);
        check_wr(0, 32'h3FFFF, 32'hF, 32'h04030201);
        check_wr(1, 32'h00000, 32'hF, e34);

        // Reset mid-job after 6 of 8 bytes.
        clear_wr();
        for (int k = 0; k < 8; k++) pv[k] = 32'(k + 1);
        run_job(18'h40, 20'd8, 5'd0, 6, 1'b0);
        @(negedge clk);
        rst_n = 1'b0; bus.in_valid_i = 1'b0; bus.start_i = 1'b0;
        #1;
        check("mid_rst_busy", 32'(bus.busy_o), 32'd0);
        check("mid_rst_ready", 32'(bus.in_ready_o), 32'd0);
        check("mid_rst_sram", {bus.sram_wdata_o[31:6], bus.sram_cs_o, bus.sram_wen_o, bus.sram_oe_o} |
                              32'(bus.sram_addr_o) | bus.sram_wdata_o, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("j6_nwr", 32'(wa.size()), 32'd1);
        check_wr(0, 32'h40, 32'hF, 32'h04030201);

        // Normal job after the abort.
        clear_wr();
        for (int k = 0; k < 4; k++) pv[k] = 32'(k + 9);
        run_job(18'h50, 20'd4, 5'd0, 4, 1'b0);
        check("j7_nwr", 32'(wa.size()), 32'd1);
        check_wr(0, 32'h50, 32'hF, 32'h0C0B0A09);

        check("idle_outputs", 32'(idle_viol), 32'd0);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
